// File: rtl/div_share_ctrl_pkg.sv
// Shared definitions for the divider-sharing controller.
package div_share_ctrl_pkg;

  localparam int unsigned DIV_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Index width for v items; never less than one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/div_share_ctrl_div.sv
// Combinational unsigned divider with zero-divisor flag.
module div_comb #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         dz
);

  // Zero divisor yields zero results and raises the flag.
  always_comb begin
    q  = '0;
    r  = '0;
    dz = 1'b0;
    if (b == '0) begin
      dz = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
    end
  end

endmodule

// File: rtl/div_share_ctrl_rr_pick.sv
// Round-robin picker: first asserted request scanning upward from ptr, wrapping.
module rr_pick
  import div_share_ctrl_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   ptr,
  output logic [N-1:0]          gnt,
  output logic [clog2(N)-1:0]   gnt_idx,
  output logic                  any
);

  localparam int unsigned IW = clog2(N);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    int unsigned   pos;
    logic [IW-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      idx = IW'(pos);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Round-robin sequencer sharing one multicycle combinational divider among N_REQ requesters.
module div_share_ctrl
  import div_share_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned W           = DIV_W,
  parameter int unsigned CALC_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*W-1:0]        req_a,
  input  logic [N_REQ*W-1:0]        req_b,
  output logic [N_REQ-1:0]          rsp_valid,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic [W-1:0]              rsp_q,
  output logic [W-1:0]              rsp_r,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [clog2(N_REQ)-1:0]   grant_id
);

  localparam int unsigned IW = clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_t        state, state_nxt;
  logic [IW-1:0] ptr;
  logic [3:0]    cnt;
  logic [W-1:0]  op_a, op_b;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  logic [W-1:0] div_q, div_r;
  logic         div_dz;

  logic xfer, calc_done, rsp_acc;

  rr_pick #(.N(N_REQ)) u_pick (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  div_comb #(.W(W)) u_div (
    .a  (op_a),
    .b  (op_b),
    .q  (div_q),
    .r  (div_r),
    .dz (div_dz)
  );

  assign req_ready = (state == ST_IDLE && !rst) ? pick_gnt : '0;
  assign xfer      = (state == ST_IDLE) && !rst && pick_any;
  assign calc_done = (state == ST_CALC) && (cnt == '0);
  assign rsp_acc   = (state == ST_RESP) && rsp_ready[grant_id];
  assign busy      = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: grant, hold the divider for CALC_CYCLES, then wait for acceptance.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (xfer)      state_nxt = ST_CALC;
      ST_CALC: if (calc_done) state_nxt = ST_RESP;
      ST_RESP: if (rsp_acc)   state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch, cycle counter, result capture and pointer advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      grant_id  <= '0;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_q     <= '0;
      rsp_r     <= '0;
      rsp_err   <= 1'b0;
      rsp_valid <= '0;
    end else begin
      if (xfer) begin
        op_a     <= req_a[pick_idx*W +: W];
        op_b     <= req_b[pick_idx*W +: W];
        grant_id <= pick_idx;
        cnt      <= 4'(CALC_CYCLES - 1);
      end
      if (state == ST_CALC) begin
        if (cnt == '0) begin
          rsp_q     <= div_dz ? '0 : div_q;
          rsp_r     <= div_dz ? '0 : div_r;
          rsp_err   <= div_dz;
          rsp_valid <= ONE << grant_id;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
      if (rsp_acc) begin
        rsp_valid <= '0;
        ptr       <= (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

endmodule
